// File: rtl/rb_pkg.sv
// rtl/rb_pkg.sv - shared state type and width helpers for the row-buffer write controller
//
// Purpose: FSM state encoding and sizing functions used by rb_write_ctrl and
//          rb_occupancy. Widths are functions because they depend on the
//          instantiating module's parameters.
package rb_pkg;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } rb_state_t;

   // $clog2 of 1 is 0; keep every vector at least one bit wide.
   function automatic int clog2_min1(input int value);
      int width;
      width = $clog2(value);
      return (width < 1) ? 1 : width;
   endfunction

   // COL_W: column / BRAM address width.
   function automatic int col_w(input int image_width);
      return clog2_min1(image_width);
   endfunction

   // OCC_W: occupancy width, must hold the value RB_COUNT itself.
   function automatic int occ_w(input int rb_count);
      return clog2_min1(rb_count + 1);
   endfunction

endpackage

// File: rtl/rb_occupancy.sv
// rtl/rb_occupancy.sv - saturating up/down counter of resident rows
//
// Purpose: counts rows written but not yet released by the read side.
// Ports:
//   clk      in   clock
//   i_clr    in   synchronous clear (highest priority)
//   i_inc    in   a row finished writing
//   i_dec    in   the read side released the oldest row
//   o_count  out  current number of resident rows, 0..MAX_COUNT
module rb_occupancy
   import rb_pkg::*;
#(
   parameter int MAX_COUNT = 8,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_count
);

   localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_COUNT);

   logic [CNT_W-1:0] r_count;

   // Simultaneous inc and dec cancel out. Both ends saturate so a stray
   // release at zero cannot wrap the count.
   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && !i_dec) begin
         if (r_count != MAX_VAL) begin
            r_count <= r_count + CNT_W'(1);
         end
      end else if (i_dec && !i_inc) begin
         if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/rb_write_ctrl.sv
// rtl/rb_write_ctrl.sv - write-side controller for the rotating row-buffer BRAM bank
//
// Purpose: accepts a raster pixel stream, writes each row into the next BRAM
//          of the bank in rotation, tracks unreleased rows and enables the
//          read-address generator once enough rows are resident.
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   in_pixel       in   incoming pixel
//   in_valid       in   pixel valid
//   in_ready       out  controller can accept a pixel
//   rd_row_done    in   read side released the oldest resident row (pulse)
//   wr_en          out  one-hot BRAM write enable (registered)
//   wr_addr        out  BRAM column address (registered)
//   wr_data        out  BRAM write data (registered)
//   read_enable    out  enable for the read-address generator
//   rows_resident  out  rows written but not yet released
//   frame_done     out  one-cycle pulse at end of frame
module rb_write_ctrl
   import rb_pkg::*;
#(
   parameter  int RB_COUNT     = 8,
   parameter  int IMAGE_WIDTH  = 256,
   parameter  int IMAGE_HEIGHT = 256,
   parameter  int PIXEL_WIDTH  = 8,
   localparam int COL_W        = col_w(IMAGE_WIDTH),
   localparam int OCC_W        = occ_w(RB_COUNT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PIXEL_WIDTH-1:0] in_pixel,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   rd_row_done,
   output logic [RB_COUNT-1:0]    wr_en,
   output logic [COL_W-1:0]       wr_addr,
   output logic [PIXEL_WIDTH-1:0] wr_data,
   output logic                   read_enable,
   output logic [OCC_W-1:0]       rows_resident,
   output logic                   frame_done
);

   localparam int SEL_W = clog2_min1(RB_COUNT);
   localparam int ROW_W = clog2_min1(IMAGE_HEIGHT);

   localparam logic [COL_W-1:0] LAST_COL   = COL_W'(IMAGE_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(IMAGE_HEIGHT - 1);
   localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(RB_COUNT - 1);
   localparam logic [OCC_W-1:0] FULL_OCC   = OCC_W'(RB_COUNT);
   localparam logic [OCC_W-1:0] STREAM_OCC = OCC_W'(RB_COUNT - 1);

   rb_state_t               r_state;
   logic [COL_W-1:0]        r_col;
   logic [ROW_W-1:0]        r_row;
   logic [SEL_W-1:0]        r_wr_sel;
   logic [RB_COUNT-1:0]     r_wr_en;
   logic [COL_W-1:0]        r_wr_addr;
   logic [PIXEL_WIDTH-1:0]  r_wr_data;
   logic                    r_read_enable;
   logic                    r_frame_done;

   logic [OCC_W-1:0]        w_occ;
   logic [RB_COUNT-1:0]     w_sel_onehot;
   logic                    w_in_ready;
   logic                    w_accept;
   logic                    w_row_wrap;
   logic                    w_last_row_wrap;

   // Ready depends only on registered state and occupancy: a full bank
   // stalls input so a row is never overwritten before release.
   assign w_in_ready      = ((r_state == FILL) || (r_state == STREAM)) && (w_occ < FULL_OCC);
   assign w_accept        = in_valid && w_in_ready;
   assign w_row_wrap      = w_accept && (r_col == LAST_COL);
   assign w_last_row_wrap = w_row_wrap && (r_row == LAST_ROW);
   assign w_sel_onehot    = RB_COUNT'(1) << r_wr_sel;

   rb_occupancy #(
      .MAX_COUNT (RB_COUNT),
      .CNT_W     (OCC_W)
   ) u_occupancy (
      .clk     (clk),
      .i_clr   (rst),
      .i_inc   (w_row_wrap),
      .i_dec   (rd_row_done),
      .o_count (w_occ)
   );

   // Write port and raster counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col     <= '0;
         r_row     <= '0;
         r_wr_sel  <= '0;
         r_wr_en   <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= '0;
         if (w_accept) begin
            r_wr_en   <= w_sel_onehot;
            r_wr_addr <= r_col;
            r_wr_data <= in_pixel;
            if (r_col == LAST_COL) begin
               r_col    <= '0;
               r_wr_sel <= (r_wr_sel == LAST_SEL) ? '0 : r_wr_sel + SEL_W'(1);
               r_row    <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
            end else begin
               r_col <= r_col + COL_W'(1);
            end
         end else if (r_state == DONE) begin
            // Next frame always starts at BRAM 0, column 0.
            r_col    <= '0;
            r_row    <= '0;
            r_wr_sel <= '0;
         end
      end
   end

   // Frame FSM with registered read_enable / frame_done.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= FILL;
         r_read_enable <= 1'b0;
         r_frame_done  <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            FILL: begin
               // A frame only as tall as the bank can finish while filling
               // in degenerate one-column images; go straight to draining.
               if (w_last_row_wrap) begin
                  r_state       <= DRAIN;
                  r_read_enable <= 1'b1;
               end else if (w_occ >= STREAM_OCC) begin
                  r_state       <= STREAM;
                  r_read_enable <= 1'b1;
               end
            end
            STREAM: begin
               if (w_last_row_wrap) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_occ == '0) begin
                  r_state       <= DONE;
                  r_read_enable <= 1'b0;
                  r_frame_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= FILL;
            end
            default: begin
               r_state       <= FILL;
               r_read_enable <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready      = w_in_ready;
   assign wr_en         = r_wr_en;
   assign wr_addr       = r_wr_addr;
   assign wr_data       = r_wr_data;
   assign read_enable   = r_read_enable;
   assign rows_resident = w_occ;
   assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_rb_write_ctrl.sv
// tb/tb_rb_write_ctrl.sv - directed self-checking bench for rb_write_ctrl
module tb_rb_write_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] in_pixel;
   logic       in_valid;
   logic       in_ready;
   logic       rd_row_done;
   logic [3:0] wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic       read_enable;
   logic [2:0] rows_resident;
   logic       frame_done;

   int checks;
   int passed;

   rb_write_ctrl #(
      .RB_COUNT     (4),
      .IMAGE_WIDTH  (8),
      .IMAGE_HEIGHT (6),
      .PIXEL_WIDTH  (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_pixel      (in_pixel),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .rd_row_done   (rd_row_done),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .read_enable   (read_enable),
      .rows_resident (rows_resident),
      .frame_done    (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ctl = {wr_en, rows_resident, read_enable, in_ready, frame_done}
   task automatic test_reset();
      logic [9:0] obs;
      logic [9:0] exp;
      rst = 1'b1; in_valid = 1'b0; rd_row_done = 1'b0; in_pixel = 8'h00;
      tick(); tick();
      obs = {wr_en, rows_resident, read_enable, in_ready, frame_done};
      exp = {4'b0000, 3'd0, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs !== exp || wr_addr !== 3'd0 || wr_data !== 8'h00)
         $display("FAIL reset_state: got ctl=%h addr=%h data=%h expected ctl=%h addr=0 data=00", obs, wr_addr, wr_data, exp);
      else passed++;
      rst = 1'b0;
   endtask

   task automatic test_fill();
      logic [20:0] obs;
      logic [20:0] exp;
      logic [7:0]  pix;
      logic [9:0]  ctl;
      for (int p = 0; p < 32; p++) begin
         pix = 8'(p * 7 + 1);
         in_valid = 1'b1; in_pixel = pix;
         tick();
         obs = {wr_en, wr_addr, wr_data, rows_resident, read_enable, in_ready, frame_done};
         exp = {4'(1 << (p / 8)), 3'(p % 8), pix, 3'((p + 1) / 8), 1'(p >= 24), 1'(p != 31), 1'b0};
         checks++;
         if (obs !== exp) $display("FAIL fill_pixel_%0d: got %h expected %h", p, obs, exp);
         else passed++;
      end
      // Bank full: valid held high must not write anything.
      in_pixel = 8'hEE;
      tick();
      ctl = {wr_en, rows_resident, read_enable, in_ready, frame_done};
      checks++;
      if (ctl !== {4'b0000, 3'd4, 1'b1, 1'b0, 1'b0}) $display("FAIL full_stall: got %h expected %h", ctl, {4'b0000, 3'd4, 1'b1, 1'b0, 1'b0});
      else passed++;
   endtask

   task automatic test_release();
      logic [9:0]  ctl;
      logic [14:0] wr;
      rd_row_done = 1'b1;
      tick();
      rd_row_done = 1'b0;
      ctl = {wr_en, rows_resident, read_enable, in_ready, frame_done};
      checks++;
      if (ctl !== {4'b0000, 3'd3, 1'b1, 1'b1, 1'b0}) $display("FAIL release_ctl: got %h expected %h", ctl, {4'b0000, 3'd3, 1'b1, 1'b1, 1'b0});
      else passed++;
      in_pixel = 8'h40;
      tick();
      wr = {wr_en, wr_addr, wr_data};
      checks++;
      if (wr !== {4'b0001, 3'd0, 8'h40}) $display("FAIL release_next_row_write: got %h expected %h", wr, {4'b0001, 3'd0, 8'h40});
      else passed++;
   endtask

   task automatic test_wrap_and_release();
      logic [9:0]  ctl;
      logic [14:0] wr;
      logic [7:0]  pix;
      for (int c = 1; c < 8; c++) begin
         pix = 8'(8'h40 + c);
         in_pixel = pix; rd_row_done = (c == 7);
         tick();
         rd_row_done = 1'b0;
         wr = {wr_en, wr_addr, wr_data};
         checks++;
         if (wr !== {4'b0001, 3'(c), pix}) $display("FAIL row4_write_%0d: got %h expected %h", c, wr, {4'b0001, 3'(c), pix});
         else passed++;
      end
      ctl = {wr_en, rows_resident, read_enable, in_ready, frame_done};
      checks++;
      if (ctl !== {4'b0001, 3'd3, 1'b1, 1'b1, 1'b0}) $display("FAIL wrap_release_same_cycle: got %h expected %h", ctl, {4'b0001, 3'd3, 1'b1, 1'b1, 1'b0});
      else passed++;
      // First pixel of the last row, with another release: BRAM 1 now.
      in_pixel = 8'h50; rd_row_done = 1'b1;
      tick();
      rd_row_done = 1'b0;
      wr = {wr_en, wr_addr, wr_data};
      checks++;
      if (wr !== {4'b0010, 3'd0, 8'h50}) $display("FAIL wr_sel_advanced: got %h expected %h", wr, {4'b0010, 3'd0, 8'h50});
      else passed++;
      checks++;
      if (rows_resident !== 3'd2) $display("FAIL release_during_row: got %0d expected 2", rows_resident);
      else passed++;
   endtask

   task automatic test_frame();
      logic [9:0]  ctl;
      logic [9:0]  exp;
      logic [14:0] wr;
      logic [7:0]  pix;
      for (int c = 1; c < 8; c++) begin
         pix = 8'(8'h50 + c);
         in_pixel = pix;
         tick();
         wr = {wr_en, wr_addr, wr_data};
         checks++;
         if (wr !== {4'b0010, 3'(c), pix}) $display("FAIL row5_write_%0d: got %h expected %h", c, wr, {4'b0010, 3'(c), pix});
         else passed++;
      end
      ctl = {wr_en, rows_resident, read_enable, in_ready, frame_done};
      checks++;
      if (ctl !== {4'b0010, 3'd3, 1'b1, 1'b0, 1'b0}) $display("FAIL enter_drain: got %h expected %h", ctl, {4'b0010, 3'd3, 1'b1, 1'b0, 1'b0});
      else passed++;
      in_pixel = 8'hEE;
      for (int k = 0; k < 3; k++) begin
         rd_row_done = 1'b1;
         tick();
         rd_row_done = 1'b0;
         ctl = {wr_en, rows_resident, read_enable, in_ready, frame_done};
         exp = {4'b0000, 3'(2 - k), 1'b1, 1'b0, 1'b0};
         checks++;
         if (ctl !== exp) $display("FAIL drain_release_%0d: got %h expected %h", k, ctl, exp);
         else passed++;
         if (k < 2) tick();
      end
      in_pixel = 8'h77;
      tick();
      ctl = {wr_en, rows_resident, read_enable, in_ready, frame_done};
      checks++;
      if (ctl !== {4'b0000, 3'd0, 1'b0, 1'b0, 1'b1}) $display("FAIL frame_done_pulse: got %h expected %h", ctl, {4'b0000, 3'd0, 1'b0, 1'b0, 1'b1});
      else passed++;
      tick();
      ctl = {wr_en, rows_resident, read_enable, in_ready, frame_done};
      checks++;
      if (ctl !== {4'b0000, 3'd0, 1'b0, 1'b1, 1'b0}) $display("FAIL back_to_fill: got %h expected %h", ctl, {4'b0000, 3'd0, 1'b0, 1'b1, 1'b0});
      else passed++;
      tick();
      in_valid = 1'b0;
      wr = {wr_en, wr_addr, wr_data};
      checks++;
      if (wr !== {4'b0001, 3'd0, 8'h77}) $display("FAIL new_frame_write: got %h expected %h", wr, {4'b0001, 3'd0, 8'h77});
      else passed++;
   endtask

   task automatic test_underflow();
      logic [9:0] ctl;
      rd_row_done = 1'b1;
      tick();
      rd_row_done = 1'b0;
      ctl = {wr_en, rows_resident, read_enable, in_ready, frame_done};
      checks++;
      if (ctl !== {4'b0000, 3'd0, 1'b0, 1'b1, 1'b0}) $display("FAIL release_at_zero: got %h expected %h", ctl, {4'b0000, 3'd0, 1'b0, 1'b1, 1'b0});
      else passed++;
   endtask

   task automatic test_reset_mid();
      logic [17:0] obs;
      logic [9:0]  ctl;
      logic [14:0] wr;
      // col is 1 on row 0; 20 more pixels leave col=5, row=2.
      in_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         in_pixel = 8'(8'h80 + n);
         tick();
      end
      in_valid = 1'b0;
      obs = {wr_en, wr_addr, wr_data, rows_resident};
      checks++;
      if (obs !== {4'b0100, 3'd4, 8'h93, 3'd2}) $display("FAIL pre_reset_position: got %h expected %h", obs, {4'b0100, 3'd4, 8'h93, 3'd2});
      else passed++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ctl = {wr_en, rows_resident, read_enable, in_ready, frame_done};
      checks++;
      if (ctl !== {4'b0000, 3'd0, 1'b0, 1'b1, 1'b0} || wr_addr !== 3'd0 || wr_data !== 8'h00)
         $display("FAIL mid_reset_state: got ctl=%h addr=%h data=%h expected ctl=%h addr=0 data=00", ctl, wr_addr, wr_data, {4'b0000, 3'd0, 1'b0, 1'b1, 1'b0});
      else passed++;
      in_valid = 1'b1; in_pixel = 8'h5A;
      tick();
      in_valid = 1'b0;
      wr = {wr_en, wr_addr, wr_data};
      checks++;
      if (wr !== {4'b0001, 3'd0, 8'h5A}) $display("FAIL post_reset_write: got %h expected %h", wr, {4'b0001, 3'd0, 8'h5A});
      else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      test_reset();
      test_fill();
      test_release();
      test_wrap_and_release();
      test_frame();
      test_underflow();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
